// File: rtl/alu_mdu.sv
// Execute unit: single-cycle ALU ops plus iterative shift-add multiply and
// restoring divide. Every result is registered and handed off over valid/ready.
module alu_mdu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned CntW = ShW + 1;

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              is_mul_q, is_mul_d;   // iterating a multiply (else a divide)
    logic              sel_hi_q, sel_hi_d;   // final value comes from the high half
    logic [XLEN-1:0]   opnd_q, opnd_d;       // multiplicand or divisor
    logic [XLEN-1:0]   hi_q, hi_d;           // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;           // multiplier / dividend-then-quotient
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              is_iter_op;
    logic [ShW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   step_hi, step_lo;

    assign in_ready   = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q == StIter);
    assign out_valid  = (state_q == StDone);
    assign result     = result_q;
    assign zero       = (result_q == '0);
    assign shamt      = src_b[ShW-1:0];
    assign is_iter_op = op inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};

    // Single-cycle operation result, computed straight from the request operands.
    always_comb begin
        alu_res = '0;
        case (op)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a & src_b;
            4'b0101: alu_res = src_a ^ src_b;
            4'b0110: alu_res = src_a << shamt;
            4'b0111: alu_res = src_a >> shamt;
            4'b1000: alu_res = $signed(src_a) >>> shamt;
            4'b1001: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            default: alu_res = '0;
        endcase
    end

    // One multiply or divide iteration on the working registers.
    always_comb begin
        // Shift-add: conditionally add, then shift {carry, hi, lo} right by one.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        // Restoring divide: shift next dividend bit into the remainder, try subtract.
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
        if (is_mul_q) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end
    end

    // Next-state logic: accept/launch, iterate, and hand off the result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        sel_hi_d = sel_hi_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;

        if (state_q == StIter) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                result_d = sel_hi_q ? step_hi : step_lo;
                state_d  = StDone;
            end
        end else if (accept) begin
            if (is_iter_op) begin
                state_d  = StIter;
                cnt_d    = CntW'(XLEN);
                is_mul_d = ~op[2];
                sel_hi_d = op[0];
                hi_d     = '0;
                lo_d     = ~op[2] ? src_b : src_a;
                opnd_d   = ~op[2] ? src_a : src_b;
            end else begin
                state_d  = StDone;
                result_d = alu_res;
            end
        end else if ((state_q == StDone) && out_ready) begin
            state_d = StIdle;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            sel_hi_q <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            sel_hi_q <= sel_hi_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed spec vectors plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_mdu;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [3:0]        op;
    logic [XLEN-1:0]   src_a, src_b, result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint unsigned p;
        logic [4:0]      sh;
        sh = b[4:0];
        p  = 64'(a) * 64'(b);
        case (o)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a ^ b;
            4'd6:    return a << sh;
            4'd7:    return a >> sh;
            4'd8:    return 32'($signed(a) >>> sh);
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return p[31:0];
            4'd11:   return p[63:32];
            4'd12:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd13:   return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] rand_single_op();
        int o;
        o = $urandom_range(0, 11);
        if (o >= 10) o = o + 4;
        return 4'(o);
    endfunction

    // Issue one request with out_ready high; scramble inputs right after accept.
    // lat counts edges from accept until out_valid is seen (-1 on timeout).
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat,
                         output int busy_cyc, output int rdy_cyc);
        int w;
        w = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        src_a = $urandom;
        src_b = $urandom;
        lat = 1;
        busy_cyc = 0;
        rdy_cyc = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (busy) busy_cyc++;
            if (in_ready) rdy_cyc++;
            @(negedge clk);
            lat++;
        end
        res = result;
        z = zero;
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 4'd0;
        src_a = '0;
        src_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b result=%h zero=%b want 0 0 0 1",
                     out_valid, busy, result, zero);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_legacy();
        vec_t v[4] = '{'{4'd0, 32'd5, 32'd7, 32'd12}, '{4'd1, 32'd9, 32'd9, 32'd0},
                       '{4'd3, 32'hF0, 32'h0F, 32'hFF}, '{4'd4, 32'hF0, 32'h0F, 32'd0}};
        logic [31:0] r, e, a, b;
        logic [3:0]  o;
        logic        z;
        int          lat, bc, rc;
        for (int i = 0; i < 4 + 40; i++) begin
            if (i < 4) begin
                o = v[i].o; a = v[i].a; b = v[i].b; e = v[i].e;
            end else begin
                o = rand_single_op(); a = $urandom; b = $urandom;
                if (i % 5 == 0) b = a;
                e = model(o, a, b);
            end
            issue(o, a, b, r, z, lat, bc, rc);
            checks++;
            if (r !== e || z !== (e == 32'd0) || lat != 1) begin
                errors++;
                $display("FAIL legacy op=%0d a=%h b=%h: result=%h zero=%b lat=%0d want %h %b 1",
                         o, a, b, r, z, lat, e, (e == 32'd0));
            end
        end
        // Idle with in_valid low: result holds, out_valid drops.
        repeat (3) @(negedge clk);
        checks++;
        if (result !== e || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: result=%h valid=%b want %h 0", result, out_valid, e);
        end
    endtask

    task automatic test_compare_shift();
        vec_t v[4] = '{'{4'd2, 32'hFFFF_FFFF, 32'd1, 32'd1},
                       '{4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0},
                       '{4'd8, 32'h8000_0000, 32'd35, 32'hF000_0000},
                       '{4'd7, 32'h8000_0000, 32'd35, 32'h1000_0000}};
        logic [31:0] r;
        logic        z;
        int          lat, bc, rc;
        for (int i = 0; i < 4; i++) begin
            issue(v[i].o, v[i].a, v[i].b, r, z, lat, bc, rc);
            checks++;
            if (r !== v[i].e || lat != 1) begin
                errors++;
                $display("FAIL cmp_shift op=%0d: result=%h lat=%0d want %h 1",
                         v[i].o, r, lat, v[i].e);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] r, e, a, b;
        logic [3:0]  o;
        logic        z;
        int          lat, bc, rc;
        for (int i = 0; i < 8; i++) begin
            if (i < 2) begin
                o = (i == 0) ? 4'd10 : 4'd11;
                a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
                e = (i == 0) ? 32'h0000_0001 : 32'hFFFF_FFFE;
            end else begin
                o = 4'(10 + (i % 2)); a = $urandom; b = $urandom;
                e = model(o, a, b);
            end
            issue(o, a, b, r, z, lat, bc, rc);
            checks++;
            if (r !== e || z !== (e == 32'd0)) begin
                errors++;
                $display("FAIL mul op=%0d a=%h b=%h: result=%h zero=%b want %h", o, a, b, r, z, e);
            end
            checks++;
            if (lat != 33 || bc != 32 || rc != 0) begin
                errors++;
                $display("FAIL mul_timing: lat=%0d busy=%0d ready=%0d want 33 32 0", lat, bc, rc);
            end
        end
    endtask

    task automatic test_div();
        vec_t v[4] = '{'{4'd12, 32'd100, 32'd7, 32'd14}, '{4'd13, 32'd100, 32'd7, 32'd2},
                       '{4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF}, '{4'd13, 32'd5, 32'd0, 32'd5}};
        logic [31:0] r, e, a, b;
        logic [3:0]  o;
        logic        z;
        int          lat, bc, rc;
        for (int i = 0; i < 4 + 10; i++) begin
            if (i < 4) begin
                o = v[i].o; a = v[i].a; b = v[i].b; e = v[i].e;
            end else begin
                o = 4'(12 + (i % 2)); a = $urandom;
                b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom >> (i % 24);
                e = model(o, a, b);
            end
            issue(o, a, b, r, z, lat, bc, rc);
            checks++;
            if (r !== e || lat != 33 || rc != 0) begin
                errors++;
                $display("FAIL div op=%0d a=%h b=%h: result=%h lat=%0d ready=%0d want %h 33 0",
                         o, a, b, r, lat, rc, e);
            end
        end
    endtask

    task automatic test_handshake();
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 4'd0; src_a = 32'd1; src_b = 32'd1;
        @(posedge clk);
        #1;
        // A competing request that must not be taken while stalled.
        op = 4'd0; src_a = 32'd9; src_b = 32'd9;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (result !== 32'd2 || out_valid !== 1'b1 || in_ready !== 1'b0 || zero !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: result=%h valid=%b in_ready=%b want 2 1 0",
                         k, result, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        op = 4'd1; src_a = 32'd3; src_b = 32'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (result !== 32'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL release_accept: result=%h valid=%b want 2 1", result, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_idle: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            op = rand_single_op();
            src_a = $urandom;
            src_b = $urandom;
            e = model(op, src_a, src_b);
            @(negedge clk);
            checks++;
            if (result !== e || out_valid !== 1'b1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d]: result=%h valid=%b ready=%b want %h 1 1",
                         i, result, out_valid, in_ready, e);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic        z;
        int          lat, bc, rc, seen;
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        op = 4'd12; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_iter_busy: busy=%b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: valid=%b busy=%b result=%h zero=%b want 0 0 0 1",
                     out_valid, busy, result, zero);
        end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL discarded_result: out_valid seen %0d cycles want 0", seen);
        end
        issue(4'd0, 32'd2, 32'd2, r, z, lat, bc, rc);
        checks++;
        if (r !== 32'd4 || lat != 1) begin
            errors++;
            $display("FAIL post_reset_add: result=%h lat=%0d want 4 1", r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_compare_shift();
        test_mul();
        test_div();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
